fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the core's combinational instruction memory.
- Owns the program counter and drives the memory address. Consumes the 32-bit `{M[a+1],M[a]}` word the memory returns.
- Decodes instruction length: 16-bit, or 32-bit with a trailing immediate halfword.
- Registers the instruction into the IF/ID pipeline register, with stall, flush/branch redirect, reset-vector load and halt.

Parameters:
- ADDR_W, 32, width of PC and memory address (halfword-indexed).
- RESET_VEC_ADDR, 0, halfword address holding the 32-bit reset vector, low half first.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  address to instruction memory.
- imem_data  in  32  combinational read data: `[15:0]` = M[addr], `[31:16]` = M[addr+1].
- stall  in  1  hold PC and IF/ID contents (load-use or structural hazard from downstream).
- flush  in  1  invalidate IF/ID next edge; PC continues sequentially.
- branch_taken  in  1  redirect PC to branch_target and invalidate IF/ID.
- branch_target  in  ADDR_W  redirect address.
- halt  in  1  decode saw HLT; freeze fetch.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  32  `[15:0]` instruction, `[31:16]` immediate (0 for 16-bit instructions).
- if_id_pc  out  ADDR_W  address of the instruction in IF/ID.
- if_id_next_pc  out  ADDR_W  sequential successor (pc+1 or pc+2), used for CALL return.
- fetch_state  out  2  current FSM state, for debug and bench.

Behaviour:
- Reset (reset_b=0, async): state=VEC; pc=RESET_VEC_ADDR; if_id_valid=0; if_id_inst=0; if_id_pc=0; if_id_next_pc=0.
- imem_addr = pc, combinationally, in every state.
- Length decode: instruction is long when `imem_data[15]==1` (LONG_BIT).
  - Long: len=2, immediate = `imem_data[31:16]`.
  - Short: len=1, `if_id_inst[31:16]` forced to 0.
- FSM states: VEC=0, RUN=1, HALTED=2. State 3 is illegal and recovers to VEC.
- VEC, one cycle:
  - On the edge, pc <= imem_data, the 32-bit reset vector. state <= RUN.
  - if_id_valid stays 0.
  - stall, flush, branch_taken and halt are ignored in VEC.
- RUN, per edge, in priority order:
  1. branch_taken: pc <= branch_target; if_id_valid <= 0; other IF/ID fields don't-care (keep them).
  2. halt: state <= HALTED; if_id_valid <= 0; pc holds.
  3. stall: pc and all IF/ID registers hold. An applied flush is dropped; stall has priority over flush only.
  4. flush: pc <= pc+len; if_id_valid <= 0.
  5. Normal: pc <= pc+len; if_id_inst, if_id_pc <= pc; if_id_next_pc <= pc+len; if_id_valid <= 1.
- branch_taken with stall asserted: branch wins. The redirected fetch is not lost.
- HALTED: pc, IF/ID and state hold. if_id_valid=0. Exit only via reset_b.
- Latency: an instruction at address A appears in IF/ID one edge after pc==A with no stall.
- Arithmetic: pc+len is modulo 2^ADDR_W. Wrap from max to 0 is silent; no trap.
- Reset mid-operation: async clear to the reset values above on reset_b falling. Re-enters VEC after release, and the vector is re-read.
- No X-propagation from the inputs into state while in HALTED or VEC.

Decomposition:
- Shared package core_pkg holds:
  - state encoding: FETCH_VEC, FETCH_RUN, FETCH_HALT;
  - LONG_BIT=15;
  - INST_W=16 and IMM_W=16;
  - function inst_len(hw) returning 1 or 2.
- One sub-module, if_id_reg: the IF/ID register with hold/clear enables. It is reused when later pipeline registers are added.
- The PC/FSM logic stays in fetch_unit.

Test Plan:
- Reset vector: M[0]=16'h0020, M[1]=16'h0000, M[0x20]=16'h1234 (short).
  - Release reset → 1 edge: pc=0x20, valid=0.
  - Next edge: if_id_inst=0x00001234, if_id_pc=0x20, next_pc=0x21, valid=1.
- Long instruction: M[0x21]=16'h8005, M[0x22]=16'hBEEF.
  - Fetch → if_id_inst=0xBEEF8005, if_id_pc=0x21, next_pc=0x23; pc becomes 0x23.
- Stall: assert stall 3 cycles mid-stream → pc and all IF/ID outputs constant for 3 edges; resume with the next sequential instruction, with no duplicate and no skip.
- Branch with stall: branch_taken=1, stall=1, branch_target=0x40 → pc=0x40, valid=0 next edge. Following edge: IF/ID holds M[0x40], if_id_pc=0x40.
- Halt: halt=1 at pc=0x25 → state=HALTED, valid=0; pc stays 0x25 for 10+ cycles despite stall and branch toggling. Pulsing reset_b low → state=VEC, pc=0.
- Wrap: force pc to 0xFFFFFFFF with a short instruction → next pc=0x00000000, if_id_next_pc=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM encoding, instruction-format constants
// and the instruction length decoder.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH_VEC  = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  localparam int LONG_BIT = 15;
  localparam int INST_W   = 16;
  localparam int IMM_W    = 16;

  // Length in halfwords: a set LONG_BIT means a trailing immediate halfword.
  function automatic logic [1:0] inst_len(input logic [INST_W-1:0] hw);
    return hw[LONG_BIT] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold and clear enables. Clearing only drops
// the valid bit; the payload keeps its last value.
import core_pkg::*;

module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = INST_W + IMM_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              i_hold,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_next_pc,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_next_pc;

  // Hold beats clear, clear beats load.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_pc      <= '0;
      r_next_pc <= '0;
    end else if (!i_hold) begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else begin
        r_valid   <= 1'b1;
        r_inst    <= i_inst;
        r_pc      <= i_pc;
        r_next_pc <= i_next_pc;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_inst    = r_inst;
  assign o_pc      = r_pc;
  assign o_next_pc = r_next_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, loads the reset vector, decodes
// instruction length and feeds the IF/ID register.
import core_pkg::*;

module fetch_unit #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_b,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              if_id_valid,
  output logic [31:0]       if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_next_pc,
  output logic [1:0]        fetch_state
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;

  logic [INST_W-1:0] w_hw;
  logic [1:0]        w_len;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [31:0]       w_inst;
  logic              w_hold;
  logic              w_clear;

  assign w_hw     = imem_data[INST_W-1:0];
  assign w_len    = inst_len(w_hw);
  assign w_pc_inc = r_pc + ADDR_W'(w_len);
  assign w_inst   = {(w_len == 2'd2) ? imem_data[31:16] : {IMM_W{1'b0}}, w_hw};

  // VEC and HALT clear the IF/ID valid bit without looking at any input.
  always_comb begin
    w_hold  = 1'b1;
    w_clear = 1'b0;
    case (r_state)
      FETCH_RUN: begin
        if (branch_taken || halt) begin
          w_hold  = 1'b0;
          w_clear = 1'b1;
        end else if (!stall) begin
          w_hold  = 1'b0;
          w_clear = flush;
        end
      end
      default: begin
        w_hold  = 1'b0;
        w_clear = 1'b1;
      end
    endcase
  end

  // Branch outranks stall so a redirect is never lost behind a hazard.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= FETCH_VEC;
      r_pc    <= RESET_VEC_ADDR;
    end else begin
      case (r_state)
        FETCH_VEC: begin
          r_pc    <= ADDR_W'(imem_data);
          r_state <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if (branch_taken) begin
            r_pc <= branch_target;
          end else if (halt) begin
            r_state <= FETCH_HALT;
          end else if (!stall) begin
            r_pc <= w_pc_inc;
          end
        end
        FETCH_HALT: begin
        end
        default: begin
          r_state <= FETCH_VEC;
          r_pc    <= RESET_VEC_ADDR;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_if_id (
    .clk       (clk),
    .reset_b   (reset_b),
    .i_hold    (w_hold),
    .i_clear   (w_clear),
    .i_inst    (w_inst),
    .i_pc      (r_pc),
    .i_next_pc (w_pc_inc),
    .o_valid   (if_id_valid),
    .o_inst    (if_id_inst),
    .o_pc      (if_id_pc),
    .o_next_pc (if_id_next_pc)
  );

  assign imem_addr   = r_pc;
  assign fetch_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a small reference model pushes expected
// IF/ID contents into a scoreboard queue, popped when the DUT loads IF/ID.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_next_pc;
  logic [1:0]  fetch_state;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] nextPc;
  } ifid_t;

  bit [15:0]   mem [0:255];
  logic [31:0] addrNext;
  ifid_t       sbQueue [$];
  ifid_t       expCur;
  logic        expValid;
  logic [1:0]  modelState;
  logic [31:0] modelPc;
  int          testsRun = 0;
  int          testsFailed = 0;

  fetch_unit #(
    .ADDR_W         (32),
    .RESET_VEC_ADDR (32'h0)
  ) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .if_id_valid   (if_id_valid),
    .if_id_inst    (if_id_inst),
    .if_id_pc      (if_id_pc),
    .if_id_next_pc (if_id_next_pc),
    .fetch_state   (fetch_state)
  );

  // 10 ns core clock.
  always #5 clk = ~clk;

  // Combinational instruction memory; only the low 8 address bits decode, so
  // the top address 0xFFFFFFFF aliases onto entry 0xFF.
  assign addrNext = imem_addr + 32'd1;
  always_comb imem_data = {mem[addrNext[7:0]], mem[imem_addr[7:0]]};

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] a1;
    a1 = a + 32'd1;
    return {mem[a1[7:0]], mem[a[7:0]]};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    modelState = 2'd0;
    modelPc    = 32'h0;
    expValid   = 1'b0;
    expCur     = '0;
    sbQueue.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".state"}, {30'b0, fetch_state}, 32'd0);
    checkOutput({tag, ".addr"},  imem_addr, 32'h0);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, 32'd0);
    checkOutput({tag, ".inst"},  if_id_inst, 32'h0);
    checkOutput({tag, ".pc"},    if_id_pc, 32'h0);
    checkOutput({tag, ".next"},  if_id_next_pc, 32'h0);
  endtask

  // Drive one cycle of control inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic s, input logic f, input logic b,
                               input logic [31:0] t, input logic h);
    bit          pushed;
    logic [15:0] hw;
    logic [31:0] len;
    pushed        = 1'b0;
    stall         = s;
    flush         = f;
    branch_taken  = b;
    branch_target = t;
    halt          = h;
    case (modelState)
      2'd0: begin
        modelPc    = memWord(modelPc);
        modelState = 2'd1;
        expValid   = 1'b0;
      end
      2'd1: begin
        if (b) begin
          modelPc  = t;
          expValid = 1'b0;
        end else if (h) begin
          modelState = 2'd2;
          expValid   = 1'b0;
        end else if (!s) begin
          hw  = mem[modelPc[7:0]];
          len = hw[15] ? 32'd2 : 32'd1;
          if (f) begin
            expValid = 1'b0;
          end else begin
            sbQueue.push_back('{inst:   hw[15] ? memWord(modelPc) : {16'h0, hw},
                                pc:     modelPc,
                                nextPc: modelPc + len});
            pushed   = 1'b1;
            expValid = 1'b1;
          end
          modelPc = modelPc + len;
        end
      end
      default: begin
      end
    endcase
    @(posedge clk);
    #1;
    if (pushed && if_id_valid === 1'b1 && sbQueue.size() != 0) expCur = sbQueue.pop_front();
    checkOutput({tag, ".state"}, {30'b0, fetch_state}, {30'b0, modelState});
    checkOutput({tag, ".addr"},  imem_addr, modelPc);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, expValid});
    if (expValid) begin
      checkOutput({tag, ".inst"}, if_id_inst, expCur.inst);
      checkOutput({tag, ".pc"},   if_id_pc, expCur.pc);
      checkOutput({tag, ".next"}, if_id_next_pc, expCur.nextPc);
    end
  endtask

  // Directed program: vector load, short/long fetch, stall, flush, branch,
  // wrap, halt and a mid-run asynchronous reset.
  initial begin
    reset_b       = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    halt          = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h00] = 16'h0020;
    mem[8'h01] = 16'h0000;
    mem[8'h20] = 16'h1234;
    mem[8'h21] = 16'h8005;
    mem[8'h22] = 16'hBEEF;
    mem[8'h23] = 16'h1111;
    mem[8'h24] = 16'h2222;
    mem[8'h25] = 16'h3333;
    mem[8'h40] = 16'h4444;
    mem[8'h41] = 16'h5555;
    mem[8'h42] = 16'h6666;
    mem[8'hFF] = 16'h0777;
    modelReset();

    #12;
    checkResetValues("reset");
    @(negedge clk);
    reset_b = 1'b1;

    applyStimulus("vec",     1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("f20",     1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("f21long", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("stall1",  1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("stall2",  1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus("stall3",  1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("f23",     1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("flush24", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus("brStall", 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    applyStimulus("f40",     1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("f41",     1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("brWrap",  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("fWrap",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("f0",      1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("br25",    1'b0, 1'b0, 1'b1, 32'h25, 1'b0);
    applyStimulus("halt",    1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("halted", i[0], i[1], ~i[0], 32'h40, i[2]);
    end

    #2;
    reset_b = 1'b0;
    #2;
    modelReset();
    checkResetValues("midReset");
    reset_b = 1'b1;

    applyStimulus("vec2",    1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    applyStimulus("f20b",    1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    checkOutput("sbEmpty", sbQueue.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
